// File: rtl/parking_lot_arbiter.sv
// parking_lot_arbiter
//   Shares one occupancy counter between N_LANES parking-lot lanes. Enter/exit
//   pulses from the lane FSMs are latched into sticky pending flags, and at most
//   one flag per cycle is granted to the counter as an inc or dec pulse. Exits
//   always win over enters. Each class is round-robin across lanes. A grant that
//   would overflow or underflow the lot is rejected with a denied pulse. An
//   accepted grant opens that lane's barrier gate for GATE_TICKS cycles.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   enter_req  : [N_LANES] one-cycle pulse per lane, car completed entry
//   exit_req   : [N_LANES] one-cycle pulse per lane, car completed exit
//   inc / dec  : one-cycle pulses to the shared counter
//   gate_open  : [N_LANES] barrier open level per lane
//   occupancy  : [CNT_WIDTH] internal occupancy mirror
//   full/empty : occupancy == CAPACITY / occupancy == 0
//   denied     : one-cycle pulse, grant rejected (lot full on enter, empty on exit)
//   overrun    : one-cycle pulse, a request merged into an already-pending flag
module parking_lot_arbiter #(
  parameter int N_LANES    = 2,
  parameter int CAPACITY   = 99,
  parameter int CNT_WIDTH  = 7,
  parameter int GATE_TICKS = 100_000_000,
  parameter int TICK_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LANES-1:0]   enter_req,
  input  logic [N_LANES-1:0]   exit_req,
  output logic                 inc,
  output logic                 dec,
  output logic [N_LANES-1:0]   gate_open,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 denied,
  output logic                 overrun
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [N_LANES-1:0]   pend_enter_reg, pend_enter_next;
  logic [N_LANES-1:0]   pend_exit_reg, pend_exit_next;
  logic [PTR_W-1:0]     rr_enter_reg, rr_enter_next;
  logic [PTR_W-1:0]     rr_exit_reg, rr_exit_next;
  logic [CNT_WIDTH-1:0] occupancy_reg, occupancy_next;
  logic                 inc_reg, dec_reg, denied_reg, overrun_reg;
  logic                 inc_next, dec_next, denied_next, overrun_next;

  logic                 exit_found, enter_found, enter_grant;
  logic [PTR_W-1:0]     exit_sel, enter_sel, idx;
  logic [N_LANES-1:0]   exit_grant_vec, enter_grant_vec, gate_load;
  logic                 at_zero, at_cap;

  assign at_zero = (occupancy_reg == '0);
  assign at_cap  = (occupancy_reg == CNT_WIDTH'(CAPACITY));

  // Round-robin search in each class, starting at that class's pointer.
  always_comb begin
    exit_found  = 1'b0;
    exit_sel    = '0;
    enter_found = 1'b0;
    enter_sel   = '0;
    idx         = '0;
    for (int off = 0; off < N_LANES; off++) begin
      idx = PTR_W'((int'(rr_exit_reg) + off) % N_LANES);
      if (!exit_found && pend_exit_reg[idx]) begin
        exit_found = 1'b1;
        exit_sel   = idx;
      end
    end
    for (int off = 0; off < N_LANES; off++) begin
      idx = PTR_W'((int'(rr_enter_reg) + off) % N_LANES);
      if (!enter_found && pend_enter_reg[idx]) begin
        enter_found = 1'b1;
        enter_sel   = idx;
      end
    end
  end

  // Exits free space, so any pending exit pre-empts every pending enter.
  assign enter_grant = enter_found && !exit_found;

  always_comb begin
    exit_grant_vec  = '0;
    enter_grant_vec = '0;
    for (int i = 0; i < N_LANES; i++) begin
      exit_grant_vec[i]  = exit_found  && (exit_sel  == PTR_W'(i));
      enter_grant_vec[i] = enter_grant && (enter_sel == PTR_W'(i));
    end
  end

  always_comb begin
    // A request in the same cycle as its own grant re-sets the flag, so the
    // new event is not lost.
    pend_exit_next  = (pend_exit_reg  & ~exit_grant_vec)  | exit_req;
    pend_enter_next = (pend_enter_reg & ~enter_grant_vec) | enter_req;
    overrun_next    = |(exit_req  & pend_exit_reg  & ~exit_grant_vec) ||
                      |(enter_req & pend_enter_reg & ~enter_grant_vec);

    dec_next       = exit_found  && !at_zero;
    inc_next       = enter_grant && !at_cap;
    // A rejected grant still clears its flag but leaves the gate shut.
    denied_next    = (exit_found && at_zero) || (enter_grant && at_cap);
    occupancy_next = occupancy_reg;
    gate_load      = '0;
    if (dec_next) begin
      occupancy_next = occupancy_reg - CNT_WIDTH'(1);
      gate_load      = exit_grant_vec;
    end else if (inc_next) begin
      occupancy_next = occupancy_reg + CNT_WIDTH'(1);
      gate_load      = enter_grant_vec;
    end

    rr_exit_next  = rr_exit_reg;
    rr_enter_next = rr_enter_reg;
    if (exit_found) begin
      rr_exit_next = (exit_sel == PTR_W'(N_LANES - 1)) ? '0 : exit_sel + PTR_W'(1);
    end else if (enter_grant) begin
      rr_enter_next = (enter_sel == PTR_W'(N_LANES - 1)) ? '0 : enter_sel + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_enter_reg <= '0;
      pend_exit_reg  <= '0;
      rr_enter_reg   <= '0;
      rr_exit_reg    <= '0;
      occupancy_reg  <= '0;
      inc_reg        <= 1'b0;
      dec_reg        <= 1'b0;
      denied_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      pend_enter_reg <= pend_enter_next;
      pend_exit_reg  <= pend_exit_next;
      rr_enter_reg   <= rr_enter_next;
      rr_exit_reg    <= rr_exit_next;
      occupancy_reg  <= occupancy_next;
      inc_reg        <= inc_next;
      dec_reg        <= dec_next;
      denied_reg     <= denied_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Per-lane gate timer; a load while open simply restarts the full period.
  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_gate
      logic [TICK_WIDTH-1:0] timer_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          timer_reg <= '0;
        end else if (gate_load[gi]) begin
          timer_reg <= TICK_WIDTH'(GATE_TICKS);
        end else if (timer_reg != '0) begin
          timer_reg <= timer_reg - TICK_WIDTH'(1);
        end
      end
      assign gate_open[gi] = (timer_reg != '0);
    end
  endgenerate

  assign inc       = inc_reg;
  assign dec       = dec_reg;
  assign denied    = denied_reg;
  assign overrun   = overrun_reg;
  assign occupancy = occupancy_reg;
  assign full      = at_cap;
  assign empty     = at_zero;

endmodule

// File: tb/tb_parking_lot_arbiter.sv
module tb_parking_lot_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] enter_req;
  logic [1:0] exit_req;
  logic       inc, dec, full, empty, denied, overrun;
  logic [1:0] gate_open;
  logic [6:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  parking_lot_arbiter #(
    .N_LANES(2), .CAPACITY(3), .CNT_WIDTH(7), .GATE_TICKS(4), .TICK_WIDTH(27)
  ) dut (
    .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
    .inc(inc), .dec(dec), .gate_open(gate_open), .occupancy(occupancy),
    .full(full), .empty(empty), .denied(denied), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a one-cycle request; returns just after the edge that sampled it.
  task automatic pulse(input logic [1:0] en, input logic [1:0] ex);
    enter_req = en;
    exit_req  = ex;
    tick();
    enter_req = 2'b00;
    exit_req  = 2'b00;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_inc"}, inc, 0);
    chk({tag, "_dec"}, dec, 0);
    chk({tag, "_denied"}, denied, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_gate"}, gate_open, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    reset     = 1'b0;
    enter_req = 2'b00;
    exit_req  = 2'b00;
    #3;
    chk_idle_outputs("rst");
    idle(2);
    reset = 1'b1;
    idle(1);

    // Single entry on lane 0: inc two edges after the request pulse.
    pulse(2'b01, 2'b00);
    chk("s1_inc_early", inc, 0);
    tick();
    chk("s1_inc", inc, 1);
    chk("s1_occ", occupancy, 1);
    chk("s1_gate", gate_open, 2'b01);
    chk("s1_empty", empty, 0);
    tick();
    chk("s1_inc_one_cycle", inc, 0);
    chk("s1_gate_c2", gate_open, 2'b01);
    idle(2);
    chk("s1_gate_c4", gate_open, 2'b01);
    tick();
    chk("s1_gate_closed", gate_open, 2'b00);

    // Bring the enter pointer back to lane 0, keep occupancy at 1.
    pulse(2'b10, 2'b00);
    tick();
    chk("setup_inc_l1", inc, 1);
    chk("setup_occ2", occupancy, 2);
    pulse(2'b00, 2'b01);
    tick();
    chk("setup_dec_l0", dec, 1);
    chk("setup_occ1", occupancy, 1);
    idle(6);
    chk("setup_gates_closed", gate_open, 2'b00);

    // Simultaneous requests: exit lane 1, then enter lane 0, then enter lane 1.
    pulse(2'b11, 2'b10);
    tick();
    chk("s2_dec", dec, 1);
    chk("s2_dec_noinc", inc, 0);
    chk("s2_occ0", occupancy, 0);
    chk("s2_gate_l1", gate_open, 2'b10);
    tick();
    chk("s2_inc_a", inc, 1);
    chk("s2_inc_a_nodec", dec, 0);
    chk("s2_occ1", occupancy, 1);
    chk("s2_gate_l0", gate_open, 2'b11);
    tick();
    chk("s2_inc_b", inc, 1);
    chk("s2_occ2", occupancy, 2);
    tick();
    chk("s2_done", inc, 0);
    tick();
    chk("s2_l1_reloaded", gate_open, 2'b11);
    tick();
    chk("s2_l0_closed", gate_open, 2'b10);
    idle(4);

    // Fill the lot, then a rejected entry on lane 1.
    pulse(2'b01, 2'b00);
    tick();
    chk("fill_inc", inc, 1);
    chk("fill_occ3", occupancy, 3);
    chk("fill_full", full, 1);
    idle(6);
    pulse(2'b10, 2'b00);
    tick();
    chk("full_noinc", inc, 0);
    chk("full_denied", denied, 1);
    chk("full_gate", gate_open, 2'b00);
    chk("full_occ", occupancy, 3);
    tick();
    chk("full_denied_one_cycle", denied, 0);
    chk("full_occ_hold", occupancy, 3);

    // Reset while a gate is open and an exit flag is still pending.
    pulse(2'b00, 2'b11);
    tick();
    chk("mid_dec", dec, 1);
    chk("mid_occ2", occupancy, 2);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_nodec", dec, 0);
      chk("post_rst_occ", occupancy, 0);
    end

    // Exit from an empty lot is rejected.
    pulse(2'b00, 2'b01);
    tick();
    chk("empty_nodec", dec, 0);
    chk("empty_denied", denied, 1);
    chk("empty_occ", occupancy, 0);
    chk("empty_gate", gate_open, 2'b00);
    tick();
    chk("empty_denied_one_cycle", denied, 0);

    // Retrigger: second lane 0 entry two cycles after the first.
    pulse(2'b01, 2'b00);
    tick();
    chk("rt_inc1", inc, 1);
    chk("rt_gate1", gate_open, 2'b01);
    pulse(2'b01, 2'b00);
    chk("rt_gap_gate", gate_open, 2'b01);
    chk("rt_gap_inc", inc, 0);
    tick();
    chk("rt_inc2", inc, 1);
    chk("rt_occ2", occupancy, 2);
    chk("rt_gate2", gate_open, 2'b01);
    idle(3);
    chk("rt_gate_hold", gate_open, 2'b01);
    tick();
    chk("rt_gate_closed", gate_open, 2'b00);

    // Drop to occupancy 1 for the overrun case.
    pulse(2'b00, 2'b01);
    tick();
    chk("ov_setup_dec", dec, 1);
    chk("ov_setup_occ", occupancy, 1);
    idle(6);

    // Lane 0 requests twice in a row while lane 1 (pointer) is granted first.
    enter_req = 2'b11;
    tick();
    enter_req = 2'b01;
    tick();
    enter_req = 2'b00;
    chk("ov_inc_l1", inc, 1);
    chk("ov_overrun", overrun, 1);
    chk("ov_occ2", occupancy, 2);
    tick();
    chk("ov_inc_l0", inc, 1);
    chk("ov_overrun_one_cycle", overrun, 0);
    chk("ov_occ3", occupancy, 3);
    chk("ov_full", full, 1);
    tick();
    chk("ov_single_inc", inc, 0);
    chk("ov_no_denied", denied, 0);
    chk("ov_occ_final", occupancy, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parking_lot_arbiter.md
# parking_lot_arbiter

Admission controller and arbiter that shares one occupancy counter between several parking-lot lanes. Each lane's occupancy FSM issues one-cycle enter/exit pulses. This block queues those pulses and grants at most one per cycle to the shared counter through `inc`/`dec`. It enforces a capacity limit and times each lane's barrier gate. It sits between the per-lane FSMs and the BCD counter / display path.

## Interface
- `N_LANES`, 2, number of lanes (each with its own enter/exit request pair)
- `CAPACITY`, 99, maximum occupancy (fits two BCD digits)
- `CNT_WIDTH`, 7, width of `occupancy`; must satisfy 2^CNT_WIDTH > CAPACITY
- `GATE_TICKS`, 100_000_000, cycles a gate stays open after a grant (1 s at 100 MHz)
- `TICK_WIDTH`, 27, width of each gate timer; must hold `GATE_TICKS`
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `enter_req`  input  N_LANES  one-cycle pulse per lane: car completed entry sequence
- `exit_req`  input  N_LANES  one-cycle pulse per lane: car completed exit sequence
- `inc`  output  1  one-cycle pulse to shared counter: increment
- `dec`  output  1  one-cycle pulse to shared counter: decrement
- `gate_open`  output  N_LANES  per-lane barrier open level
- `occupancy`  output  CNT_WIDTH  internal occupancy mirror
- `full`  output  1  `occupancy == CAPACITY`
- `empty`  output  1  `occupancy == 0`
- `denied`  output  1  one-cycle pulse when a request is rejected because the lot is full (enter) or empty (exit)
- `overrun`  output  1  one-cycle pulse when a request merges into an already-pending flag

## Operation
- **Pending flags.** Each lane has two sticky flags, `pend_enter[i]` and `pend_exit[i]`.
  - A request pulse sets its flag.
  - A grant clears its flag.
  - If a request and a grant of the same flag occur in the same cycle, the set wins and the new event is kept.
  - If a request arrives while its flag is set and not being granted, the two merge and `overrun` pulses.
- **Arbitration.** Each cycle at most one flag is granted.
  - Any pending exit beats any pending enter, because exits free space.
  - Within a class, round-robin: separate pointers `rr_exit` and `rr_enter`. Search starts at the pointer and wraps modulo N_LANES.
  - After a grant, that class's pointer moves to granted lane + 1, wrapping from N_LANES−1 to 0. The other pointer is unchanged.
- **Exit grant, lane i.**
  - If `occupancy > 0`: `dec` = 1, `occupancy` −1, lane i gate timer loads.
  - If `occupancy == 0`: no `dec`, `denied` = 1, gate stays closed, flag is still cleared.
- **Enter grant, lane i.**
  - If `occupancy < CAPACITY`: `inc` = 1, `occupancy` +1, lane i gate timer loads.
  - If `occupancy == CAPACITY`: no `inc`, `denied` = 1, gate stays closed, flag is still cleared.
- **Occupancy arithmetic.** Never wraps. Saturation is impossible by construction; `inc` and `dec` are never asserted together.
- **Gate timer.**
  - Per-lane down-counter. A load sets it to `GATE_TICKS`.
  - `gate_open[i]` = timer ≠ 0; it decrements each cycle while nonzero.
  - A new grant on a lane whose gate is open reloads the timer to `GATE_TICKS` (retrigger, no gap).
- **Reset (async, active-low).** Clears all flags, pointers, timers and `occupancy`, mid-operation included. In-flight requests are lost.

## Timing
- Reset values:
  - `inc`=0, `dec`=0, `denied`=0, `overrun`=0
  - `gate_open`=0, `occupancy`=0
  - `full`=0, `empty`=1
- Request pulse sampled at edge k sets its flag at edge k.
- The grant decision is combinational from the flags in cycle k..k+1. The resulting `inc`/`dec`/`denied`, the `occupancy` update and the gate load are registered at edge k+1.
- Minimum latency from request pulse to `inc`/`dec`: 2 cycles; it grows by 1 cycle per higher-priority pending flag ahead of it.
- Worst-case wait: 2·N_LANES cycles after the last request in a burst.
- `gate_open[i]` rises on the same edge as `inc`/`dec`. It stays high exactly `GATE_TICKS` cycles without retrigger.
- `full` and `empty` are combinational from the `occupancy` register and change on the same edge as `occupancy`.
- `overrun` is registered: it pulses the cycle after the merging request.

## Test plan
Bench uses `GATE_TICKS`=4, `CAPACITY`=3.

- **Reset and single entry.** Release reset; pulse `enter_req`=01 → `inc` high 1 cycle, 2 cycles after the pulse; `occupancy`=1; `gate_open`=01 for exactly 4 cycles; `empty` falls.
- **Simultaneous requests, exit priority and round-robin.** With `occupancy`=1, pulse `enter_req`=11 and `exit_req`=10 in the same cycle → `dec` (lane 1), then `inc` (lane 0), then `inc` (lane 1) on consecutive cycles; final `occupancy`=2.
- **Full lot.** From `occupancy`=3 (`full`=1), pulse `enter_req`=10 → no `inc`, `denied` 1 cycle, `gate_open`=00, `occupancy` stays 3.
- **Empty lot.** From reset, pulse `exit_req`=01 → no `dec`, `denied` 1 cycle, `occupancy` stays 0.
- **Retrigger and overrun.**
  - Pulse lane 0 enter twice, 2 cycles apart → gate stays high continuously, for 4 cycles after the second `inc`.
  - Pulse lane 0 enter on consecutive cycles while its flag is held pending behind lane 1 → `overrun` 1 cycle, only one `inc` for lane 0.
- **Reset mid-operation.** Assert `reset`=0 while gates are open and flags are pending → all outputs return to reset values immediately (asynchronous); no `inc`/`dec` after release.
